// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: sequencing controller for a downstream clock gating cell.
//
// Opens the shared gate when any requester (or software force) asks for it,
// waits a wake-up settle time, then grants requesters concurrently. The gate
// closes only after a run of idle cycles with no demand. A saturating counter
// records how many cycles the gate was open.
//
// Ports:
//   i_clk       ungated system clock
//   i_rstn      asynchronous active-low reset
//   i_req       per-requester level request (four-phase req/ack)
//   i_force_on  software override, holds the gate open while high (no ack)
//   i_cnt_clr   synchronous clear of o_on_cnt (wins over increment)
//   o_clock_en  registered enable to the gating cell
//   o_ack       registered per-requester grant
//   o_state     FSM state: OFF=0, WAKE=1, ON=2, HOLD=3
//   o_on_cnt    saturating count of cycles with o_clock_en=1

// One grant flop per requester; the ack follows its request only while the
// controller is (or is about to be) in ON.
module clk_gate_ack_lane (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_grant,
    input  logic i_req,
    output logic o_ack
);
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) o_ack <= 1'b0;
        else         o_ack <= i_grant & i_req;
    end
endmodule

module clk_gate_ctrl #(
    parameter int NUM_REQ  = 4,
    parameter int WAKE_CYC = 4,
    parameter int IDLE_CYC = 16,
    parameter int CNT_W    = 8
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_force_on,
    input  logic               i_cnt_clr,
    output logic               o_clock_en,
    output logic [NUM_REQ-1:0] o_ack,
    output logic [1:0]         o_state,
    output logic [15:0]        o_on_cnt
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             demand;
    logic             en_d;
    logic             grant;

    // Force-on counts as one more request, it just never gets an ack.
    assign demand = (|i_req) | i_force_on;

    // State register, wake/idle down-counter, gate enable and on-cycle counter.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            o_clock_en <= 1'b0;
            o_on_cnt   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            o_clock_en <= en_d;
            if (i_cnt_clr)
                o_on_cnt <= '0;
            else if (o_clock_en && o_on_cnt != 16'hFFFF)
                o_on_cnt <= o_on_cnt + 16'd1;
        end
    end

    // Next-state logic. WAKE always runs to completion so the gated clock
    // has settled before anyone is granted, even if the request went away.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_OFF: begin
                if (demand) begin
                    state_d = ST_WAKE;
                    cnt_d   = WAKE_LD;
                end
            end
            ST_WAKE: begin
                if (cnt_q == '0) state_d = ST_ON;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            ST_ON: begin
                if (!demand) begin
                    state_d = ST_HOLD;
                    cnt_d   = IDLE_LD;
                end
            end
            ST_HOLD: begin
                // Demand is checked before expiry so a request arriving on
                // the last idle cycle keeps the gate open.
                if (demand)             state_d = ST_ON;
                else if (cnt_q == '0)   state_d = ST_OFF;
                else                    cnt_d   = cnt_q - CNT_ONE;
            end
        endcase
    end

    // Outputs are registered, so they are decoded from the next state:
    // the gate opens on the edge leaving OFF, acks appear on the edge
    // entering ON and clear on the edge leaving it.
    always_comb begin
        en_d  = (state_d != ST_OFF);
        grant = (state_d == ST_ON);
    end

    assign o_state = state_q;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        clk_gate_ack_lane u_lane (
            .i_clk   (i_clk),
            .i_rstn  (i_rstn),
            .i_grant (grant),
            .i_req   (i_req[g]),
            .o_ack   (o_ack[g])
        );
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: directed vectors, a cycle-level reference model
// that tracks elapsed wake/idle time counting upward, and a compare process
// checking every DUT output against it on each falling edge.
module tb_clk_gate_ctrl;

    localparam int NUM_REQ  = 4;
    localparam int WAKE_CYC = 4;
    localparam int IDLE_CYC = 16;

    logic               i_clk;
    logic               i_rstn;
    logic [NUM_REQ-1:0] i_req;
    logic               i_force_on;
    logic               i_cnt_clr;
    logic               o_clock_en;
    logic [NUM_REQ-1:0] o_ack;
    logic [1:0]         o_state;
    logic [15:0]        o_on_cnt;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: phase 0=OFF 1=WAKE 2=ON 3=HOLD.
    int                 m_phase;
    int                 m_wake_elapsed;
    int                 m_idle_elapsed;
    logic               m_en;
    logic [NUM_REQ-1:0] m_ack;
    int                 m_cnt;

    clk_gate_ctrl #(
        .NUM_REQ  (NUM_REQ),
        .WAKE_CYC (WAKE_CYC),
        .IDLE_CYC (IDLE_CYC),
        .CNT_W    (8)
    ) dut (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_req      (i_req),
        .i_force_on (i_force_on),
        .i_cnt_clr  (i_cnt_clr),
        .o_clock_en (o_clock_en),
        .o_ack      (o_ack),
        .o_state    (o_state),
        .o_on_cnt   (o_on_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase        = 0;
        m_wake_elapsed = 0;
        m_idle_elapsed = 0;
        m_en           = 1'b0;
        m_ack          = '0;
        m_cnt          = 0;
    endtask

    // Advance the model by one rising edge using the inputs sampled there.
    task automatic model_step();
        logic dem;
        dem = (|i_req) | i_force_on;
        if (!i_rstn) begin
            model_reset();
            return;
        end
        if (i_cnt_clr)                  m_cnt = 0;
        else if (m_en && m_cnt < 65535) m_cnt = m_cnt + 1;
        case (m_phase)
            0: if (dem) begin m_phase = 1; m_wake_elapsed = 0; end
            1: begin
                m_wake_elapsed++;
                if (m_wake_elapsed == WAKE_CYC) m_phase = 2;
            end
            2: if (!dem) begin m_phase = 3; m_idle_elapsed = 1; end
            default: begin
                if (dem) m_phase = 2;
                else begin
                    m_idle_elapsed++;
                    // gate stays open for IDLE_CYC full cycles in HOLD
                    if (m_idle_elapsed == IDLE_CYC + 1) m_phase = 0;
                end
            end
        endcase
        m_en  = (m_phase != 0);
        m_ack = (m_phase == 2) ? i_req : '0;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk);
            model_step();
            @(negedge i_clk);
        end
    endtask

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge i_clk) begin
        check("clock_en", 32'(o_clock_en), 32'(m_en));
        check("ack",      32'(o_ack),      32'(m_ack));
        check("state",    32'(o_state),    32'(m_phase));
        check("on_cnt",   32'(o_on_cnt),   32'(m_cnt));
        check("inv_ack_implies_on", 32'((o_ack == '0) || (o_clock_en && o_state == 2'd2)), 32'd1);
    end

    initial begin
        model_reset();
        i_req      = '0;
        i_force_on = 1'b0;
        i_cnt_clr  = 1'b0;
        i_rstn     = 1'b1;
        #1 i_rstn  = 1'b0;

        // Reset state
        cyc(3);
        check("rst_state", 32'(o_state), 32'd0);
        check("rst_en",    32'(o_clock_en), 32'd0);
        check("rst_cnt",   32'(o_on_cnt), 32'd0);
        i_rstn = 1'b1;
        cyc(2);

        // Single requester: open, 4 cycles of WAKE, then grant
        i_req = 4'b0001;
        cyc(1);
        check("open_en",    32'(o_clock_en), 32'd1);
        check("open_state", 32'(o_state), 32'd1);
        cyc(3);
        check("wake_last_state", 32'(o_state), 32'd1);
        check("wake_no_ack",     32'(o_ack), 32'd0);
        cyc(1);
        check("grant_state", 32'(o_state), 32'd2);
        check("grant_ack",   32'(o_ack), 32'h1);
        cyc(5);

        // Drop request: ack falls, HOLD for 16 cycles, then close
        i_req = '0;
        cyc(1);
        check("drop_ack",   32'(o_ack), 32'd0);
        check("drop_state", 32'(o_state), 32'd3);
        cyc(15);
        check("hold_end_en", 32'(o_clock_en), 32'd1);
        cyc(1);
        check("close_en",    32'(o_clock_en), 32'd0);
        check("close_state", 32'(o_state), 32'd0);

        // Re-request in HOLD after 5 cycles: straight back to ON with ack
        i_req = 4'b0001;
        cyc(5);
        i_req = '0;
        cyc(5);
        i_req = 4'b0100;
        cyc(1);
        check("rehold_state", 32'(o_state), 32'd2);
        check("rehold_ack",   32'(o_ack), 32'h4);
        check("rehold_en",    32'(o_clock_en), 32'd1);
        i_req = '0;
        cyc(17);
        check("rehold_close", 32'(o_state), 32'd0);

        // One-cycle pulse: full WAKE, one ON cycle without ack, HOLD, OFF
        i_cnt_clr = 1'b1;
        cyc(1);
        i_cnt_clr = 1'b0;
        check("clr_cnt", 32'(o_on_cnt), 32'd0);
        i_req = 4'b0001;
        cyc(1);
        i_req = '0;
        cyc(4);
        check("pulse_on",    32'(o_state), 32'd2);
        check("pulse_noack", 32'(o_ack), 32'd0);
        cyc(1);
        check("pulse_hold",  32'(o_state), 32'd3);
        cyc(15);
        check("pulse_hold_end", 32'(o_state), 32'd3);
        cyc(1);
        check("pulse_off",   32'(o_state), 32'd0);
        check("pulse_cnt",   32'(o_on_cnt), 32'd21);

        // Software force-on: gate open, no acks
        i_force_on = 1'b1;
        cyc(100);
        check("force_en",  32'(o_clock_en), 32'd1);
        check("force_ack", 32'(o_ack), 32'd0);
        i_force_on = 1'b0;
        cyc(16);
        check("force_rel_en", 32'(o_clock_en), 32'd1);
        cyc(1);
        check("force_rel_close", 32'(o_clock_en), 32'd0);

        // Counter saturation and clear priority
        i_cnt_clr = 1'b1;
        cyc(1);
        i_cnt_clr  = 1'b0;
        i_force_on = 1'b1;
        cyc(65535);
        check("cnt_fffe", 32'(o_on_cnt), 32'h0000_FFFE);
        cyc(5);
        check("cnt_sat", 32'(o_on_cnt), 32'h0000_FFFF);
        i_cnt_clr = 1'b1;
        cyc(1);
        check("cnt_clr_prio", 32'(o_on_cnt), 32'd0);
        i_cnt_clr  = 1'b0;
        i_force_on = 1'b0;
        cyc(18);
        check("sat_close", 32'(o_state), 32'd0);

        // Concurrent requesters, one dropping alone, then async reset in ON
        i_req = 4'b1010;
        cyc(5);
        check("multi_ack", 32'(o_ack), 32'hA);
        i_req = 4'b1000;
        cyc(1);
        check("single_drop_ack", 32'(o_ack), 32'h8);
        i_req = 4'b1010;
        cyc(1);
        #2 i_rstn = 1'b0;
        model_reset();
        #1;
        check("arst_en",    32'(o_clock_en), 32'd0);
        check("arst_ack",   32'(o_ack), 32'd0);
        check("arst_cnt",   32'(o_on_cnt), 32'd0);
        check("arst_state", 32'(o_state), 32'd0);
        cyc(2);
        i_rstn = 1'b1;
        cyc(1);
        check("restart_wake", 32'(o_state), 32'd1);
        cyc(4);
        check("restart_ack", 32'(o_ack), 32'hA);
        i_req = '0;
        cyc(20);
        check("final_off", 32'(o_state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
